// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings, default geometry
// and the ceiling-log2 helper used to size pointers.
package fifo_pkg;

   localparam int FIFO_MODE_STD      = 0;
   localparam int FIFO_MODE_FWFT     = 1;

   localparam int FIFO_DEFAULT_WIDTH = 8;
   localparam int FIFO_DEFAULT_DEPTH = 4;

   // Smallest n with 2**n >= value. Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((longint'(1) << i) < longint'(value)) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH = FIFO_DEFAULT_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: one entry per accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count,
// sticky overflow/underflow and a selectable standard or FWFT read path.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = FIFO_MODE_STD,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             write_en,
   input  logic             read_en,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   DEPTH_C     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AFULL_C     = (AW+1)'(AFULL_TH);
   localparam logic [AW:0]   AEMPTY_C    = (AW+1)'(AEMPTY_TH);
   localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic          FWFT_ENABLE = (FWFT == FIFO_MODE_FWFT);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             rd_acc;
   logic             wr_acc;
   logic [WIDTH-1:0] ram_rdata;

   // A read in the same cycle frees a slot, so a full FIFO accepts read+write together.
   assign rd_acc = read_en & ~empty;
   assign wr_acc = write_en & (~full | rd_acc);

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Next-state for pointers, occupancy, registered read data and error flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      dout_d      = dout_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = ram_rdata;
      end else begin
         rd_ptr_d = rd_ptr_q;
         dout_d   = dout_q;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A fresh error beats a simultaneous clear.
      overflow_d  = (write_en & ~wr_acc) | (overflow_q & ~clr_err);
      underflow_d = (read_en & empty) | (underflow_q & ~clr_err);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {(AW+1){1'b0}};
         dout_q      <= {WIDTH{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign count        = count_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == {(AW+1){1'b0}});
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // FWFT shows the head entry directly; it reads as zero while empty so reset gives dout=0.
   assign dout = FWFT_ENABLE ? (empty ? {WIDTH{1'b0}} : ram_rdata) : dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO driven with the
// same directed and random stimulus, both compared against a queue model.
module tb_fifo_sync_param;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         write_en;
   logic         read_en;
   logic         clr_err;

   logic [W-1:0] s_dout, f_dout;
   logic         s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
   logic         f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
   logic [2:0]   s_count, f_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   logic         m_ovf;
   logic         m_unf;

   fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .din(din), .write_en(write_en), .read_en(read_en),
      .clr_err(clr_err), .dout(s_dout), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf)
   );

   fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .din(din), .write_en(write_en), .read_en(read_en),
      .clr_err(clr_err), .dout(f_dout), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"},  32'(s_count),  32'(n));
      chk({tag, ".empty"},  32'(s_empty),  32'(n == 0));
      chk({tag, ".full"},   32'(s_full),   32'(n == D));
      chk({tag, ".afull"},  32'(s_afull),  32'(n >= 3));
      chk({tag, ".aempty"}, 32'(s_aempty), 32'(n <= 1));
      chk({tag, ".ovf"},    32'(s_ovf),    32'(m_ovf));
      chk({tag, ".unf"},    32'(s_unf),    32'(m_unf));
      chk({tag, ".dout"},   32'(s_dout),   32'(m_dout));
      chk({tag, ".f_count"}, 32'(f_count), 32'(n));
      chk({tag, ".f_flags"}, 32'({f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf}),
          32'({n == D, n == 0, n >= 3, n <= 1, m_ovf, m_unf}));
      if (n > 0) begin
         chk({tag, ".f_dout"}, 32'(f_dout), 32'(q[0]));
      end else begin
         chk({tag, ".f_empty_only"}, 32'(f_empty), 32'(1));
      end
   endtask

   // One clock of stimulus; the model applies the FIFO rules at the edge, then outputs are checked.
   task automatic step(input string tag, input logic we, input logic re,
                       input logic [W-1:0] d, input logic clr);
      bit rd_ok, wr_ok;
      write_en = we;
      read_en  = re;
      din      = d;
      clr_err  = clr;
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < D) || rd_ok);
      @(posedge clk);
      m_ovf = (we && !wr_ok) || (m_ovf && !clr);
      m_unf = (re && q.size() == 0) || (m_unf && !clr);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; din = 8'h00; write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // Fill to full, then one dropped write
      step("fill1", 1'b1, 1'b0, 8'hA1, 1'b0);
      step("fill2", 1'b1, 1'b0, 8'hA2, 1'b0);
      step("fill3", 1'b1, 1'b0, 8'hA3, 1'b0);
      step("fill4", 1'b1, 1'b0, 8'hA4, 1'b0);
      step("ovf",   1'b1, 1'b0, 8'hA5, 1'b0);

      // Drain, one underflowing read, then clear errors
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      step("unf",   1'b0, 1'b1, 8'h00, 1'b0);
      step("clr",   1'b0, 1'b0, 8'h00, 1'b1);

      // Full plus simultaneous read/write, then mixed ops across the wrap
      for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
      step("full_rw", 1'b1, 1'b1, 8'hB0, 1'b0);
      for (int i = 0; i < 8; i++) step("mixed", 1'b1, 1'(i % 2 == 0), 8'(8'hB1 + i), 1'b0);
      step("clr2",  1'b0, 1'b0, 8'h00, 1'b1);

      // Empty plus simultaneous read/write
      while (q.size() > 0) step("drain2", 1'b0, 1'b1, 8'h00, 1'b0);
      step("empty_rw", 1'b1, 1'b1, 8'hC7, 1'b0);
      step("read_c7",  1'b0, 1'b1, 8'h00, 1'b1);

      // FWFT head visibility
      step("w3c",  1'b1, 1'b0, 8'h3C, 1'b0);
      step("w5a",  1'b1, 1'b0, 8'h5A, 1'b0);
      step("r3c",  1'b0, 1'b1, 8'h00, 1'b0);
      step("r5a",  1'b0, 1'b1, 8'h00, 1'b0);

      // Asynchronous reset between edges with two entries held
      step("pre_rst1", 1'b1, 1'b0, 8'h21, 1'b0);
      step("pre_rst2", 1'b1, 1'b0, 8'h22, 1'b0);
      step("pre_rst3", 1'b0, 1'b1, 8'h00, 1'b0);
      step("pre_rst4", 1'b1, 1'b0, 8'h23, 1'b0);
      write_en = 1'b0; read_en = 1'b0;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b1;
      step("post_w11", 1'b1, 1'b0, 8'h11, 1'b0);
      step("post_r11", 1'b0, 1'b1, 8'h00, 1'b0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
